// File: rtl/mul_div_unit_if.sv
// Issue/writeback handshake bundle for mul_div_unit: request side (in_*),
// result side (out_*) and the busy status flag.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_src1;
    logic [WIDTH-1:0] in_src2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             busy;

    modport master (
        output in_valid, in_op, in_src1, in_src2, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply / restoring divide unit with valid/ready handshakes.
// Optional macro MUL_DIV_UNIT_CANCEL_EN adds a flush input 'cancel'.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic clk,
    input  logic reset,
`ifdef MUL_DIV_UNIT_CANCEL_EN
    input  logic cancel,
`endif
    mul_div_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [2:0] OP_MUL_W   = 3'd0;
    localparam logic [2:0] OP_MULH_W  = 3'd1;
    localparam logic [2:0] OP_MULH_WU = 3'd2;
    localparam logic [2:0] OP_DIV_W   = 3'd3;
    localparam logic [2:0] OP_MOD_W   = 3'd4;
    localparam logic [2:0] OP_DIV_WU  = 3'd5;
    localparam logic [2:0] OP_MOD_WU  = 3'd6;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               cancel_s;
    logic               accept_s;
    logic               new_div_s;
    logic               new_signed_s;
    logic               ext1_s, ext2_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     rem_shift_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic [WIDTH-1:0]   quot_next_s;
    logic               op_is_quot_s;

    // Next-state, datapath and registered-output computation
    always_comb begin
`ifdef MUL_DIV_UNIT_CANCEL_EN
        cancel_s = cancel;
`else
        cancel_s = 1'b0;
`endif
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        result_d    = result_q;

        accept_s     = bus.in_valid & in_ready_q & ~cancel_s;
        new_div_s    = (bus.in_op >= OP_DIV_W) && (bus.in_op <= OP_MOD_WU);
        new_signed_s = (bus.in_op == OP_DIV_W) || (bus.in_op == OP_MOD_W);
        op_is_quot_s = (op_q == OP_DIV_W) || (op_q == OP_DIV_WU);

        // Operands widened to 2*WIDTH; the low 2*WIDTH product bits match the
        // (WIDTH+1)-bit signed multiply for both signed and unsigned forms.
        ext1_s = ((op_q == OP_MUL_W) || (op_q == OP_MULH_W)) ? a_q[WIDTH-1] : 1'b0;
        ext2_s = ((op_q == OP_MUL_W) || (op_q == OP_MULH_W)) ? b_q[WIDTH-1] : 1'b0;
        prod_s = {{WIDTH{ext1_s}}, a_q} * {{WIDTH{ext2_s}}, b_q};

        // One restoring step: quot_q shifts the dividend out and quotient bits in.
        rem_shift_s = {rem_q, quot_q[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, b_q};
        if (diff_s[WIDTH] == 1'b0) begin
            rem_next_s  = diff_s[WIDTH-1:0];
            quot_next_s = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s  = rem_shift_s[WIDTH-1:0];
            quot_next_s = {quot_q[WIDTH-2:0], 1'b0};
        end

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    op_d = bus.in_op;
                    if (new_div_s) begin
                        s1_d = new_signed_s & bus.in_src1[WIDTH-1];
                        s2_d = new_signed_s & bus.in_src2[WIDTH-1];
                        if (bus.in_src2 == {WIDTH{1'b0}}) begin
                            if ((bus.in_op == OP_DIV_W) || (bus.in_op == OP_DIV_WU)) begin
                                result_d = {WIDTH{1'b1}};
                            end else begin
                                result_d = bus.in_src1;
                            end
                            state_d = S_DONE;
                        end else begin
                            quot_d  = (new_signed_s & bus.in_src1[WIDTH-1]) ? -bus.in_src1 : bus.in_src1;
                            b_d     = (new_signed_s & bus.in_src2[WIDTH-1]) ? -bus.in_src2 : bus.in_src2;
                            rem_d   = {WIDTH{1'b0}};
                            cnt_d   = {CNT_W{1'b0}};
                            state_d = S_DIV;
                        end
                    end else begin
                        a_d     = bus.in_src1;
                        b_d     = bus.in_src2;
                        s1_d    = 1'b0;
                        s2_d    = 1'b0;
                        state_d = S_MUL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                case (op_q)
                    OP_MUL_W:               result_d = prod_s[WIDTH-1:0];
                    OP_MULH_W, OP_MULH_WU:  result_d = prod_s[2*WIDTH-1:WIDTH];
                    default:                result_d = {WIDTH{1'b0}};
                endcase
                state_d = S_DONE;
            end
            S_DIV: begin
                rem_d  = rem_next_s;
                quot_d = quot_next_s;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    if (op_is_quot_s) begin
                        result_d = (s1_q ^ s2_q) ? -quot_next_s : quot_next_s;
                    end else begin
                        result_d = s1_q ? -rem_next_s : rem_next_s;
                    end
                    state_d = S_DONE;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DONE: begin
                if (out_valid_q & bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cancel_s) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State, operand and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            quot_q      <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; exercises the cancel path
// instead of reset for the abort scenario when MUL_DIV_UNIT_CANCEL_EN is defined.
module tb_mul_div_unit;
    logic clk;
    logic reset;
`ifdef MUL_DIV_UNIT_CANCEL_EN
    logic cancel;
`endif
    int n_checks;
    int n_fail;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MUL_DIV_UNIT_CANCEL_EN
        .cancel(cancel),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op, measure latency from the accept edge, check result, consume it.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string name);
        int guard;
        int lat;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_in_ready: got %b expected 1", name, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_src1  = a;
        bus.in_src2  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_op    = 3'd0;
        bus.in_src1  = 32'd0;
        bus.in_src2  = 32'd0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid === 1'b1) break;
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (bus.out_result !== exp_res) begin
            n_fail++;
            $display("FAIL %s_result: got %h expected %h", name, bus.out_result, exp_res);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result: got %h expected 0", bus.out_result); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        run_op(3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 2, "mul_w");
        run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 2, "mulh_w");
        run_op(3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 2, "mulh_wu");
        run_op(3'd7, 32'h12345678, 32'h00000003, 32'h00000000, 2, "reserved");
    endtask

    task automatic test_div();
        run_op(3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, "div_w");
        run_op(3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, "mod_w");
        run_op(3'd5, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33, "div_wu");
        run_op(3'd6, 32'h00000064, 32'h00000007, 32'h00000002, 33, "mod_wu");
    endtask

    task automatic test_overflow();
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, "ovf_div");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, "ovf_mod");
    endtask

    task automatic test_div_zero();
        run_op(3'd5, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1, "dz_div_wu");
        run_op(3'd4, 32'h00001234, 32'h00000000, 32'h00001234, 1, "dz_mod_w");
    endtask

    task automatic test_backpressure();
        int guard;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'd0;
        bus.in_src1   = 32'd7;
        bus.in_src2   = 32'd6;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_result !== 32'd42 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold: result=%h valid=%b in_ready=%b busy=%b expected 0000002a 1 0 1",
                         bus.out_result, bus.out_valid, bus.in_ready, bus.busy);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
        end
        run_op(3'd0, 32'd2, 32'd3, 32'd6, 2, "bp_next");
    endtask

    task automatic test_abort();
        int seen;
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd3;
        bus.in_src1  = 32'd100;
        bus.in_src2  = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
`ifdef MUL_DIV_UNIT_CANCEL_EN
        cancel = 1'b1;
`else
        reset = 1'b1;
`endif
        @(posedge clk);
        #1;
`ifdef MUL_DIV_UNIT_CANCEL_EN
        cancel = 1'b0;
`else
        reset = 1'b0;
`endif
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: out_valid=%b in_ready=%b busy=%b expected 0 1 0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_result: got %0d valid cycles expected 0", seen);
        end
        run_op(3'd0, 32'd3, 32'd5, 32'h0000000F, 2, "abort_next");
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
`ifdef MUL_DIV_UNIT_CANCEL_EN
        cancel        = 1'b0;
`endif
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_src1   = 32'd0;
        bus.in_src2   = 32'd0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_mul();
        test_div();
        test_overflow();
        test_div_zero();
        test_backpressure();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
